// File: rtl/morra_cinese_param.sv
// ============================================================================
// Module      : morra_cinese_param
// Description : Two-player rock-paper-scissors match referee with round limit,
//               winning margin and optional no-repeat rule (MORRA_NO_REPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morra_cinese_param #(
    parameter int MIN_ROUNDS  = 4,
    parameter int WIN_MARGIN  = 2,
    parameter int BASE_ROUNDS = 4,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             INIZIA,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] ROUND,
    output logic [CNT_W:0]   LEAD,
    output logic             FINE
);

    localparam logic [CNT_W-1:0] c_MIN_ROUNDS  = CNT_W'(MIN_ROUNDS);
    localparam logic [CNT_W:0]   c_WIN_MARGIN  = (CNT_W+1)'(WIN_MARGIN);
    localparam logic [CNT_W-1:0] c_BASE_ROUNDS = CNT_W'(BASE_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PLAY  = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_limit;

    logic             w_draw;
    logic             w_p1_wins;
    logic             w_blocked;
    logic             w_valid;
    logic [1:0]       w_res;
    logic [CNT_W-1:0] w_round_nx;
    logic [CNT_W:0]   w_lead_nx;
    logic [CNT_W:0]   w_lead_abs;
    logic             w_lead_neg;
    logic             w_margin_hit;
    logic             w_limit_hit;
    logic [1:0]       w_final_res;

    assign w_draw    = (PRIMO == SECONDO);
    assign w_p1_wins = (PRIMO == 2'b01 && SECONDO == 2'b11) ||
                       (PRIMO == 2'b10 && SECONDO == 2'b01) ||
                       (PRIMO == 2'b11 && SECONDO == 2'b10);

`ifdef MORRA_NO_REPEAT_EN
    logic [1:0] r_last1;
    logic [1:0] r_last2;

    // Cleared stored moves are 00, which never matches a legal move.
    assign w_blocked = w_draw ? (PRIMO == r_last1 || PRIMO == r_last2) :
                       w_p1_wins ? (PRIMO == r_last1) : (SECONDO == r_last2);
`else
    assign w_blocked = 1'b0;
`endif

    assign w_valid    = (PRIMO != 2'b00) && (SECONDO != 2'b00) && !w_blocked;
    assign w_res      = !w_valid ? 2'b00 : w_draw ? 2'b11 : w_p1_wins ? 2'b01 : 2'b10;
    assign w_round_nx = ROUND + CNT_W'(w_valid);

    always_comb begin
        w_lead_nx = LEAD;
        if (w_res == 2'b01)
            w_lead_nx = LEAD + (CNT_W+1)'(1);
        else if (w_res == 2'b10)
            w_lead_nx = LEAD - (CNT_W+1)'(1);
    end

    assign w_lead_neg   = w_lead_nx[CNT_W];
    assign w_lead_abs   = w_lead_neg ? (~w_lead_nx + (CNT_W+1)'(1)) : w_lead_nx;
    assign w_margin_hit = (w_round_nx >= c_MIN_ROUNDS) && (w_lead_abs >= c_WIN_MARGIN);
    assign w_limit_hit  = (w_round_nx == r_limit);
    // A margin hit always has a non-zero lead, so one sign decode serves both endings.
    assign w_final_res  = w_lead_neg ? 2'b10 : (w_lead_nx == '0) ? 2'b11 : 2'b01;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_limit <= '0;
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
            ROUND   <= '0;
            LEAD    <= '0;
            FINE    <= 1'b0;
`ifdef MORRA_NO_REPEAT_EN
            r_last1 <= 2'b00;
            r_last2 <= 2'b00;
`endif
        end else if (INIZIA) begin
            r_state <= S_SETUP;
            r_limit <= CNT_W'({PRIMO, SECONDO}) + c_BASE_ROUNDS;
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
            ROUND   <= '0;
            LEAD    <= '0;
            FINE    <= 1'b0;
`ifdef MORRA_NO_REPEAT_EN
            r_last1 <= 2'b00;
            r_last2 <= 2'b00;
`endif
        end else begin
            case (r_state)
                S_SETUP, S_PLAY: begin
                    MANCHE <= w_res;
                    ROUND  <= w_round_nx;
                    LEAD   <= w_lead_nx;
`ifdef MORRA_NO_REPEAT_EN
                    if (w_res == 2'b01) begin
                        r_last1 <= PRIMO;
                        r_last2 <= 2'b00;
                    end else if (w_res == 2'b10) begin
                        r_last1 <= 2'b00;
                        r_last2 <= SECONDO;
                    end else if (w_res == 2'b11) begin
                        r_last1 <= 2'b00;
                        r_last2 <= 2'b00;
                    end
`endif
                    if (w_margin_hit || w_limit_hit) begin
                        PARTITA <= w_final_res;
                        FINE    <= 1'b1;
                        r_state <= S_END;
                    end else begin
                        r_state <= S_PLAY;
                    end
                end
                S_END: begin
                    MANCHE <= 2'b00;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morra_cinese_param.sv
// ============================================================================
// Module      : tb_morra_cinese_param
// Description : Directed self-checking bench for morra_cinese_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morra_cinese_param;

    localparam int CNT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             INIZIA;
    logic [1:0]       PRIMO;
    logic [1:0]       SECONDO;
    logic [1:0]       MANCHE;
    logic [1:0]       PARTITA;
    logic [CNT_W-1:0] ROUND;
    logic [CNT_W:0]   LEAD;
    logic             FINE;

    int n_tests = 0;
    int n_fail  = 0;

    morra_cinese_param #(
        .MIN_ROUNDS (4),
        .WIN_MARGIN (2),
        .BASE_ROUNDS(4),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INIZIA (INIZIA),
        .PRIMO  (PRIMO),
        .SECONDO(SECONDO),
        .MANCHE (MANCHE),
        .PARTITA(PARTITA),
        .ROUND  (ROUND),
        .LEAD   (LEAD),
        .FINE   (FINE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] p1, input logic [1:0] p2, input logic ini);
        PRIMO   = p1;
        SECONDO = p2;
        INIZIA  = ini;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".manche"},  32'(MANCHE),  32'h0);
        check({tag, ".partita"}, 32'(PARTITA), 32'h0);
        check({tag, ".round"},   32'(ROUND),   32'h0);
        check({tag, ".lead"},    32'(LEAD),    32'h0);
        check({tag, ".fine"},    32'(FINE),    32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        INIZIA  = 1'b0;
        PRIMO   = 2'b00;
        SECONDO = 2'b00;
        #2;
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        // Limit 10, alternating G1/G2 wins end in a draw on the limit.
        step(2'b01, 2'b10, 1'b1);
        check("lim.setup_fine", 32'(FINE), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 2'b11, 1'b0);
            if (i == 0) begin
                check("lim.r1_manche", 32'(MANCHE), 32'h1);
                check("lim.r1_round",  32'(ROUND),  32'h1);
                check("lim.r1_lead",   32'(LEAD),   32'h1);
            end
            if (i == 4) begin
                check("lim.r9_partita", 32'(PARTITA), 32'h0);
                check("lim.r9_fine",    32'(FINE),    32'h0);
            end
            step(2'b11, 2'b01, 1'b0);
            if (i == 0) check("lim.r2_manche", 32'(MANCHE), 32'h2);
        end
        check("lim.round",   32'(ROUND),   32'd10);
        check("lim.lead",    32'(LEAD),    32'h0);
        check("lim.partita", 32'(PARTITA), 32'h3);
        check("lim.fine",    32'(FINE),    32'h1);

        // Restart from END with limit 4; G1 sweeps four rounds.
        step(2'b00, 2'b00, 1'b1);
        check("restart.partita", 32'(PARTITA), 32'h0);
        check("restart.fine",    32'(FINE),    32'h0);
        check("restart.round",   32'(ROUND),   32'h0);
        step(2'b01, 2'b11, 1'b0);
        check("sweep.r1_round",  32'(ROUND),  32'h1);
        check("sweep.r1_manche", 32'(MANCHE), 32'h1);
        step(2'b10, 2'b01, 1'b0);
        step(2'b11, 2'b10, 1'b0);
        check("sweep.r3_partita", 32'(PARTITA), 32'h0);
        step(2'b01, 2'b11, 1'b0);
        check("sweep.lead",    32'(LEAD),    32'h4);
        check("sweep.partita", 32'(PARTITA), 32'h1);
        check("sweep.fine",    32'(FINE),    32'h1);
        check("sweep.manche",  32'(MANCHE),  32'h1);
        step(2'b11, 2'b01, 1'b0);
        check("end.manche", 32'(MANCHE), 32'h0);
        check("end.round",  32'(ROUND),  32'h4);
        check("end.lead",   32'(LEAD),   32'h4);

        // Limit 19: three draws then two G2 wins end early on margin.
        step(2'b11, 2'b11, 1'b1);
        step(2'b01, 2'b01, 1'b0);
        check("g2.draw_manche", 32'(MANCHE), 32'h3);
        step(2'b10, 2'b10, 1'b0);
        step(2'b11, 2'b11, 1'b0);
        step(2'b11, 2'b01, 1'b0);
        check("g2.r4_fine", 32'(FINE), 32'h0);
        check("g2.r4_lead", 32'(LEAD), 32'h3F);
        step(2'b01, 2'b10, 1'b0);
        check("g2.round",   32'(ROUND),   32'd5);
        check("g2.lead",    32'(LEAD),    32'h3E);
        check("g2.partita", 32'(PARTITA), 32'h2);
        check("g2.fine",    32'(FINE),    32'h1);

        // All-invalid stream keeps counters at zero.
        step(2'b10, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 2'b01, 1'b0);
            check_all_zero("inval");
        end

        // Repeated G1 win: blocked only with the no-repeat rule.
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b11, 1'b0);
        check("rep.r1_round", 32'(ROUND), 32'h1);
        step(2'b01, 2'b11, 1'b0);
`ifdef MORRA_NO_REPEAT_EN
        check("rep.manche", 32'(MANCHE), 32'h0);
        check("rep.round",  32'(ROUND),  32'h1);
`else
        check("rep.manche", 32'(MANCHE), 32'h1);
        check("rep.round",  32'(ROUND),  32'h2);
`endif

        // Asynchronous reset mid-PLAY, then IDLE ignores moves.
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(2'b01, 2'b11, 1'b0);
        check("idle.manche", 32'(MANCHE), 32'h0);
        check("idle.round",  32'(ROUND),  32'h0);

        // Abort mid-match: the INIZIA edge's moves are not scored.
        step(2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b11, 1'b0);
        step(2'b10, 2'b01, 1'b1);
        check("abort.round",  32'(ROUND),  32'h0);
        check("abort.manche", 32'(MANCHE), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
